// File: rtl/lfsr_rand_range.sv
// Parametrised Fibonacci LFSR with zero-lock-safe seeding and a request/response
// engine that returns values in 0..RANGE-1 by bounded rejection sampling.
module lfsr_rand_range #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
   parameter logic [WIDTH-1:0] INIT_SEED = 8'hA5,
   parameter int               RANGE     = 9,
   parameter int               OUT_W     = 4,
   parameter int               MAX_TRIES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_value,
   output logic             rsp_fallback,
   output logic [WIDTH-1:0] raw
);

   // Handshakes: a transfer happens on an edge where valid and ready are both
   // high; valid never drops before its transfer, and rsp_value/rsp_fallback
   // stay constant while rsp_valid is high.

   localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
   localparam logic [OUT_W:0]   RANGE_V  = (OUT_W + 1)'(RANGE);

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_rand_range: WIDTH must be 3..32");
   end
   if (INIT_SEED == '0) begin : g_bad_seed
      $error("lfsr_rand_range: INIT_SEED must be nonzero");
   end
   if (OUT_W > WIDTH || RANGE < 2 || RANGE > (2 ** OUT_W)) begin : g_bad_range
      $error("lfsr_rand_range: need OUT_W <= WIDTH and 2 <= RANGE <= 2**OUT_W");
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("lfsr_rand_range: MAX_TRIES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      HOLD = 2'd2
   } fsm_t;

   fsm_t             fsm_q;
   fsm_t             fsm_d;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_next;
   logic             feedback;
   logic             advance;
   logic [TRY_W-1:0] try_q;
   logic [TRY_W-1:0] try_d;
   logic [OUT_W-1:0] value_q;
   logic [OUT_W-1:0] value_d;
   logic             fb_q;
   logic             fb_d;
   logic [OUT_W-1:0] cand;
   logic             cand_ok;

   assign feedback   = ^(state_q & TAPS);
   assign state_next = {state_q[WIDTH-2:0], feedback};

   // DRAW consumes one state per candidate, so it forces the advance.
   assign advance = en | (fsm_q == DRAW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT_SEED;
      end else if (seed_load) begin
         state_q <= (seed_in == '0) ? INIT_SEED : seed_in;
      end else if (advance) begin
         state_q <= state_next;
      end
   end

   assign cand    = state_q[OUT_W-1:0];
   assign cand_ok = ({1'b0, cand} < RANGE_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         try_q   <= '0;
         value_q <= '0;
         fb_q    <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         try_q   <= try_d;
         value_q <= value_d;
         fb_q    <= fb_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      try_d   = try_q;
      value_d = value_q;
      fb_d    = fb_q;
      case (fsm_q)
         IDLE: begin
            if (req_valid) begin
               fsm_d = DRAW;
               try_d = '0;
            end
         end
         DRAW: begin
            if (cand_ok) begin
               value_d = cand;
               fb_d    = 1'b0;
               fsm_d   = HOLD;
            end else if (try_q == LAST_TRY) begin
               value_d = '0;
               fb_d    = 1'b1;
               fsm_d   = HOLD;
            end else begin
               try_d = try_q + TRY_W'(1);
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   assign req_ready    = (fsm_q == IDLE);
   assign rsp_valid    = (fsm_q == HOLD);
   assign rsp_value    = value_q;
   assign rsp_fallback = fb_q;
   assign raw          = state_q;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Bench for lfsr_rand_range: directed scenarios plus randomized traffic checked
// against a transaction-level model of the LFSR sequence and sampling rule.
module tb_lfsr_rand_range;

   localparam logic [7:0] TAPS      = 8'hB8;
   localparam logic [7:0] SEED      = 8'hA5;
   localparam int         RANGE     = 9;
   localparam int         MAX_TRIES = 16;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance a: default parameters
   logic       en = 0, seed_load = 0, req_valid = 0, rsp_ready = 0;
   logic [7:0] seed_in = '0;
   logic       req_ready, rsp_valid, rsp_fallback;
   logic [3:0] rsp_value;
   logic [7:0] raw;

   // instance b: MAX_TRIES = 1
   logic       en_b = 0, seed_load_b = 0, req_valid_b = 0, rsp_ready_b = 0;
   logic [7:0] seed_in_b = '0;
   logic       req_ready_b, rsp_valid_b, rsp_fallback_b;
   logic [3:0] rsp_value_b;
   logic [7:0] raw_b;

   lfsr_rand_range #(.WIDTH(8), .TAPS(TAPS), .INIT_SEED(SEED), .RANGE(RANGE),
                     .OUT_W(4), .MAX_TRIES(MAX_TRIES)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
      .req_valid(req_valid), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_value(rsp_value), .rsp_fallback(rsp_fallback),
      .raw(raw)
   );

   lfsr_rand_range #(.WIDTH(8), .TAPS(TAPS), .INIT_SEED(SEED), .RANGE(RANGE),
                     .OUT_W(4), .MAX_TRIES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .seed_load(seed_load_b), .seed_in(seed_in_b),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
      .rsp_ready(rsp_ready_b), .rsp_value(rsp_value_b), .rsp_fallback(rsp_fallback_b),
      .raw(raw_b)
   );

   // scoreboard
   int          n_checks = 0;
   int          n_errors = 0;
   logic [4:0]  exp_q[$];     // {fallback, value}
   logic [7:0]  m_state;      // model of the LFSR state
   logic [3:0]  exp_val;
   logic        exp_fb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference: one step of the LFSR, feedback = parity of the tapped bits
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      int ones;
      ones = $countones(s & TAPS);
      return {s[6:0], ((ones % 2) == 1)};
   endfunction

   function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
      logic [7:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

   // reference sampling: walk the sequence from s, first low nibble < RANGE wins
   task automatic predict(input logic [7:0] s, input int tries,
                          output int k, output logic [3:0] v, output logic fb);
      logic [7:0] cur;
      cur = s;
      k = tries - 1;
      v = 4'd0;
      fb = 1'b1;
      for (int t = 0; t < tries; t++) begin
         if (int'(cur[3:0]) < RANGE) begin
            k = t;
            v = cur[3:0];
            fb = 1'b0;
            break;
         end
         cur = lfsr_step(cur);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 0; seed_load = 0; seed_in = '0; req_valid = 0; rsp_ready = 0;
      en_b = 0; seed_load_b = 0; seed_in_b = '0; req_valid_b = 0; rsp_ready_b = 0;
      tick();
      tick();
      rst_n = 1'b1;
      m_state = SEED;
   endtask

   task automatic idle_cycle(input bit do_rand);
      en = do_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      seed_load = do_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      tick();
      if (seed_load) m_state = (seed_in == 8'h00) ? SEED : seed_in;
      else if (en) m_state = lfsr_step(m_state);
      seed_load = 0;
      check("idle_raw", raw, m_state);
      check("idle_req_ready", req_ready, 1);
   endtask

   task automatic do_request(input bit rand_en, output int lat);
      int k;
      logic [3:0] v;
      logic fb;
      bit found;
      req_valid = 1;
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (en) m_state = lfsr_step(m_state);
      req_valid = 0;
      check("draw_req_ready", req_ready, 0);
      predict(m_state, MAX_TRIES, k, v, fb);
      exp_q.push_back({fb, v});
      lat = 0;
      found = 0;
      while (!found && lat < MAX_TRIES + 2) begin
         en = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         lat++;
         if (rsp_valid) found = 1;
      end
      en = 0;
      check("rsp_latency", lat, k + 1);
      m_state = lfsr_adv(m_state, k + 1);
      {exp_fb, exp_val} = exp_q.pop_front();
      check("rsp_value", rsp_value, exp_val);
      check("rsp_fallback", rsp_fallback, exp_fb);
      check("rsp_raw", raw, m_state);
   endtask

   task automatic do_hold(input int n, input bit rand_en);
      for (int i = 0; i < n; i++) begin
         rsp_ready = 0;
         en = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         if (en) m_state = lfsr_step(m_state);
         check("hold_valid", rsp_valid, 1);
         check("hold_value", rsp_value, exp_val);
         check("hold_fallback", rsp_fallback, exp_fb);
         check("hold_req_ready", req_ready, 0);
         check("hold_raw", raw, m_state);
      end
      rsp_ready = 1;
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (en) m_state = lfsr_step(m_state);
      rsp_ready = 0;
      en = 0;
      check("ack_valid", rsp_valid, 0);
      check("ack_req_ready", req_ready, 1);
      check("ack_raw", raw, m_state);
   endtask

   logic [7:0] walk_exp[4];
   bit         seen[256];

   initial begin
      int lat;
      int first_ret, zero_cnt, dup_cnt;
      walk_exp = '{8'h4A, 8'h95, 8'h2A, 8'h54};

      // reset state and free-run walk
      do_reset();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_value", rsp_value, 0);
      check("rst_rsp_fallback", rsp_fallback, 0);
      check("rst_req_ready", req_ready, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_en0", raw, 8'hA5);
      end
      en = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("walk", raw, walk_exp[i]);
      end
      en = 0;

      // first two requests from reset with en low
      do_reset();
      do_request(0, lat);
      check("dir1_lat", lat, 1);
      check("dir1_value", rsp_value, 5);
      check("dir1_raw", raw, 8'h4A);
      do_hold(0, 0);
      do_request(0, lat);
      check("dir2_lat", lat, 2);
      check("dir2_value", rsp_value, 5);
      check("dir2_fallback", rsp_fallback, 0);
      do_hold(0, 0);

      // fallback with MAX_TRIES = 1
      do_reset();
      seed_load_b = 1; seed_in_b = 8'h4A;
      tick();
      seed_load_b = 0;
      check("fb_seed", raw_b, 8'h4A);
      req_valid_b = 1;
      tick();
      req_valid_b = 0;
      check("fb_draw_ready", req_ready_b, 0);
      check("fb_draw_valid", rsp_valid_b, 0);
      tick();
      check("fb_valid", rsp_valid_b, 1);
      check("fb_value", rsp_value_b, 0);
      check("fb_flag", rsp_fallback_b, 1);
      check("fb_raw", raw_b, 8'h95);
      rsp_ready_b = 1;
      tick();
      rsp_ready_b = 0;
      check("fb_ack", rsp_valid_b, 0);

      // seed loading: zero-lock, plain load, load beats en
      do_reset();
      seed_load = 1; seed_in = 8'h00;
      tick();
      check("seed_zero", raw, 8'hA5);
      seed_in = 8'h3C;
      tick();
      check("seed_3c", raw, 8'h3C);
      en = 1; seed_in = 8'h11;
      tick();
      check("seed_vs_en", raw, 8'h11);
      seed_load = 0; en = 0;

      // seed_load during DRAW replaces the advance, candidate from old state
      seed_load = 1; seed_in = 8'h4A;
      tick();
      seed_load = 0;
      req_valid = 1;
      tick();
      req_valid = 0;
      seed_load = 1; seed_in = 8'h33;
      tick();
      seed_load = 0;
      check("drawload_valid", rsp_valid, 0);
      check("drawload_raw", raw, 8'h33);
      tick();
      check("drawload_rsp", rsp_valid, 1);
      check("drawload_value", rsp_value, 3);
      check("drawload_raw2", raw, lfsr_step(8'h33));
      rsp_ready = 1;
      tick();
      rsp_ready = 0;

      // full period under continuous en
      do_reset();
      foreach (seen[i]) seen[i] = 0;
      seen[8'hA5] = 1;
      first_ret = 0; zero_cnt = 0; dup_cnt = 0;
      en = 1;
      for (int c = 1; c <= 255; c++) begin
         tick();
         if (raw == 8'h00) zero_cnt++;
         if (raw == 8'hA5 && first_ret == 0) first_ret = c;
         if (seen[raw] && c < 255) dup_cnt++;
         seen[raw] = 1;
      end
      en = 0;
      check("period", first_ret, 255);
      check("period_zero", zero_cnt, 0);
      check("period_dup", dup_cnt, 0);

      // long HOLD, then reset in the middle of it
      do_reset();
      do_request(0, lat);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("long_hold_value", rsp_value, 5);
         check("long_hold_valid", rsp_valid, 1);
         check("long_hold_ready", req_ready, 0);
      end
      #2;
      rst_n = 0;
      #1;
      check("midhold_rst_valid", rsp_valid, 0);
      check("midhold_rst_raw", raw, 8'hA5);
      check("midhold_rst_value", rsp_value, 0);
      check("midhold_rst_ready", req_ready, 1);

      // randomized traffic
      do_reset();
      for (int t = 0; t < 60; t++) begin
         int gap;
         gap = $urandom_range(0, 6);
         for (int g = 0; g < gap; g++) idle_cycle(1);
         do_request(1, lat);
         do_hold($urandom_range(0, 4), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
